ro_sensor_scheduler: RTL and testbench
======================================

Name: ro_sensor_scheduler

Overview:
Sequences a bank of NUM_SENSORS ring-oscillator sensors through measurement sweeps, one sensor at a time. It pulses each enabled sensor's enable, waits out the measurement window, then captures that sensor's count. It compares the count against an alarm threshold and emits one result per sensor on a valid/ready stream. It sits between the host/debugger configuration registers and the ro_sensor instances, which share one measurement-time bus.

Parameters:
NUM_SENSORS, 4, number of ro_sensor instances controlled (1..64)
WIDTH, 64, count and measurement-time width; matches ro_sensor width_size
EN_HOLD, 2, cycles ro_counter_en is held high per measurement (>=1)
SETTLE, 4, extra clk cycles waited after meas_time before the count is sampled (covers sensor RST_VALS/OUT_READY and r_out domain lag)
CH_W, $clog2(NUM_SENSORS) min 1, channel index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep
stop  in  1  one-cycle request to end continuous operation after the current channel
continuous  in  1  1 = restart the sweep at its end until stop; sampled at start
chan_mask  in  NUM_SENSORS  channels included in the sweep; sampled at start
meas_time  in  WIDTH  measurement window in clk cycles; sampled at start
alarm_threshold  in  WIDTH  count strictly below this raises alarm; sampled at start
ro_counter_en  out  NUM_SENSORS  one-hot or zero enable to the sensors
ro_meas_time  out  WIDTH  shadowed meas_time driven to all sensors
ro_meas_count  in  NUM_SENSORS*WIDTH  packed counts; channel i at [i*WIDTH +: WIDTH]
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_chan  out  CH_W  channel of the result
res_count  out  WIDTH  captured count
res_alarm  out  1  res_count < threshold
busy  out  1  high in any state except IDLE
sweep_done  out  1  one-cycle pulse at the end of each sweep

Behaviour:
- Reset (async, immediate): state IDLE; every output 0, including ro_counter_en, ro_meas_time, res_*, busy and sweep_done. Shadow registers and stop_pending are cleared. A reset mid-measurement drops the enable at once and does not emit a result.
- States: IDLE, ARM, WAIT, CAPTURE, EMIT, NEXT. All transitions occur on posedge clk.
- IDLE: on start with chan_mask != 0:
  - latch the shadows: mask, meas_time, threshold, continuous;
  - set chan to the lowest set bit;
  - go to ARM.
  A start with mask == 0 is ignored: no busy, no sweep_done.
- ARM: ro_counter_en[chan] = 1 for exactly EN_HOLD cycles, then go to WAIT. Enable is never asserted for more than one channel.
- WAIT: the wait counter is WIDTH+1 bits and counts from 0. Leave when counter == shadow_meas_time + SETTLE; the addition is done at WIDTH+1 bits, so there is no wrap. meas_time = 0 gives a wait of SETTLE cycles.
- CAPTURE (1 cycle):
  - res_count <= ro_meas_count[chan];
  - res_alarm <= (count < threshold);
  - res_chan <= chan;
  - go to EMIT.
- EMIT: res_valid = 1. res_* stay stable until res_valid && res_ready. On the handshake, res_valid drops the next cycle and the state goes to NEXT. While res_ready is low, stay in EMIT and enable no sensor.
- NEXT (1 cycle): find the next set mask bit strictly above chan.
  - A bit is found: set chan to it and go to ARM.
  - No bit is found: pulse sweep_done. Then, if continuous and not stop_pending, chan = lowest set bit and go to ARM; otherwise go to IDLE.
- stop: sets stop_pending in any busy state. stop_pending does not abort the current channel; the sweep finishes its current EMIT, then returns to IDLE from NEXT (sweep_done pulses only if the sweep completed). stop_pending clears on entering IDLE. stop in IDLE has no effect.
- A start while busy is ignored. chan_mask, meas_time and threshold changes during a sweep are ignored until the next start.
- busy falls in the cycle the state returns to IDLE.
- Per-channel latency with res_ready held high: EN_HOLD + (meas_time+SETTLE+1) + 1 + 1 + 1 cycles.

Decomposition:
- Package ro_sched_pkg: state enum (2-bit encodings are not enough, so 3-bit), default EN_HOLD/SETTLE constants, and a function returning the index width.
- Sub-module ro_next_chan_finder: combinational; inputs mask and current index plus a "from_start" flag; outputs next index and a found flag. It is instantiated once and used for both the first channel and the NEXT lookup.

Test Plan:
- Single sweep: NUM_SENSORS=4, mask=4'b1011, meas_time=10, counts {ch0=100, ch1=50, ch3=7}, threshold=60, res_ready=1 -> results (0,100,0), (1,50,1), (3,7,1) in order; ch2 is never enabled; one sweep_done; busy then 0.
- Backpressure: same setup with res_ready held low 20 cycles on the first result -> res_* stable throughout; ro_counter_en stays 0 until the handshake; no result is lost or duplicated.
- Continuous + stop: mask=4'b0001, continuous=1 -> sweep_done each sweep. Stop asserted during the WAIT of the 3rd sweep -> the 3rd result is emitted, the 3rd sweep_done pulses, then IDLE.
- Boundaries: mask=0 start -> no activity. meas_time=0 -> capture after EN_HOLD+SETTLE+1 wait cycles. meas_time=2^64-1 -> the wait counter does not wrap (check with a forced counter preload). Threshold=0 -> alarm never set.
- Reset mid-WAIT: rst high asynchronously -> ro_counter_en, res_valid and busy are 0 before the next edge. After release, a new start with mask=4'b0100 -> sweep of ch2 only.
- Config change mid-sweep: change meas_time and mask during the ch0 measurement -> the remaining channels use the latched values; start pulses while busy are ignored.

Source files
------------

// File: rtl/ro_sched_pkg.sv
// Shared constants for the ring-oscillator sensor scheduler: FSM encodings,
// default timing parameters and the channel-index width helper.
package ro_sched_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;

    localparam int EN_HOLD_DEF = 2;
    localparam int SETTLE_DEF  = 4;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_next_chan_finder.sv
// Finds the lowest set mask bit, either anywhere (from_start) or strictly
// above the current channel index.
module ro_next_chan_finder #(
    parameter int N    = 4,
    parameter int CH_W = 2
) (
    input  logic [N-1:0]    mask,
    input  logic [CH_W-1:0] cur,
    input  logic            from_start,
    output logic [CH_W-1:0] nxt,
    output logic            found
);

    // Scan downward so the last hit, the lowest qualifying bit, wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_sensor_scheduler.sv
// Sweeps a bank of ring-oscillator sensors one channel at a time and streams
// each captured count, with a low-count alarm, over a valid/ready interface.
module ro_sensor_scheduler
    import ro_sched_pkg::*;
#(
    parameter int NUM_SENSORS = 4,
    parameter int WIDTH       = 64,
    parameter int EN_HOLD     = EN_HOLD_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int CH_W        = ch_width(NUM_SENSORS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         continuous,
    input  logic [NUM_SENSORS-1:0]       chan_mask,
    input  logic [WIDTH-1:0]             meas_time,
    input  logic [WIDTH-1:0]             alarm_threshold,
    output logic [NUM_SENSORS-1:0]       ro_counter_en,
    output logic [WIDTH-1:0]             ro_meas_time,
    input  logic [NUM_SENSORS*WIDTH-1:0] ro_meas_count,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [CH_W-1:0]              res_chan,
    output logic [WIDTH-1:0]             res_count,
    output logic                         res_alarm,
    output logic                         busy,
    output logic                         sweep_done
);

    typedef logic [WIDTH:0] cnt_t;

    logic [2:0]             state_q, state_d;
    logic [CH_W-1:0]        chan_q, chan_d;
    logic [CH_W-1:0]        first_q, first_d;
    cnt_t                   cnt_q, cnt_d;
    logic [NUM_SENSORS-1:0] mask_q, mask_d;
    logic [WIDTH-1:0]       mt_q, mt_d;
    logic [WIDTH-1:0]       thr_q, thr_d;
    logic                   cont_q, cont_d;
    logic                   stop_pending_q, stop_pending_d;
    logic [NUM_SENSORS-1:0] en_q, en_d;
    logic                   sweep_done_q, sweep_done_d;
    logic [CH_W-1:0]        res_chan_q, res_chan_d;
    logic [WIDTH-1:0]       res_count_q, res_count_d;
    logic                   res_alarm_q, res_alarm_d;

    logic [NUM_SENSORS-1:0] fnd_mask;
    logic                   fnd_from_start;
    logic [CH_W-1:0]        fnd_nxt;
    logic                   fnd_found;
    logic [WIDTH-1:0]       cnt_sel;
    cnt_t                   wait_lim;
    logic                   stop_eff;

    // One finder serves both the first-channel pick in IDLE and the NEXT step.
    ro_next_chan_finder #(
        .N    (NUM_SENSORS),
        .CH_W (CH_W)
    ) u_finder (
        .mask       (fnd_mask),
        .cur        (chan_q),
        .from_start (fnd_from_start),
        .nxt        (fnd_nxt),
        .found      (fnd_found)
    );

    assign fnd_from_start = (state_q == S_IDLE);
    assign fnd_mask       = fnd_from_start ? chan_mask : mask_q;
    assign cnt_sel        = ro_meas_count[chan_q*WIDTH +: WIDTH];
    // One extra bit so meas_time near all-ones cannot wrap the wait limit.
    assign wait_lim       = {1'b0, mt_q} + cnt_t'(SETTLE);
    assign stop_eff       = stop_pending_q || stop;

    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        first_d        = first_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        mt_d           = mt_q;
        thr_d          = thr_q;
        cont_d         = cont_q;
        stop_pending_d = stop_pending_q;
        sweep_done_d   = 1'b0;
        res_chan_d     = res_chan_q;
        res_count_d    = res_count_q;
        res_alarm_d    = res_alarm_q;

        if (state_q != S_IDLE && stop) stop_pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                stop_pending_d = 1'b0;
                if (start && fnd_found) begin
                    mask_d  = chan_mask;
                    mt_d    = meas_time;
                    thr_d   = alarm_threshold;
                    cont_d  = continuous;
                    chan_d  = fnd_nxt;
                    first_d = fnd_nxt;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (cnt_q == cnt_t'(EN_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_lim) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                res_chan_d  = chan_q;
                res_count_d = cnt_sel;
                res_alarm_d = (cnt_sel < thr_q);
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                cnt_d = '0;
                if (fnd_found && !stop_eff) begin
                    chan_d  = fnd_nxt;
                    state_d = S_ARM;
                end else if (fnd_found) begin
                    stop_pending_d = 1'b0;
                    state_d        = S_IDLE;
                end else begin
                    sweep_done_d = 1'b1;
                    if (cont_q && !stop_eff) begin
                        chan_d  = first_q;
                        state_d = S_ARM;
                    end else begin
                        stop_pending_d = 1'b0;
                        state_d        = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Enable is registered from the next state so it tracks ARM exactly.
        en_d = '0;
        if (state_d == S_ARM) en_d[chan_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            chan_q         <= '0;
            first_q        <= '0;
            cnt_q          <= '0;
            mask_q         <= '0;
            mt_q           <= '0;
            thr_q          <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            en_q           <= '0;
            sweep_done_q   <= 1'b0;
            res_chan_q     <= '0;
            res_count_q    <= '0;
            res_alarm_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            first_q        <= first_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            mt_q           <= mt_d;
            thr_q          <= thr_d;
            cont_q         <= cont_d;
            stop_pending_q <= stop_pending_d;
            en_q           <= en_d;
            sweep_done_q   <= sweep_done_d;
            res_chan_q     <= res_chan_d;
            res_count_q    <= res_count_d;
            res_alarm_q    <= res_alarm_d;
        end
    end

    assign ro_counter_en = en_q;
    assign ro_meas_time  = mt_q;
    assign res_valid     = (state_q == S_EMIT);
    assign res_chan      = res_chan_q;
    assign res_count     = res_count_q;
    assign res_alarm     = res_alarm_q;
    assign busy          = (state_q != S_IDLE);
    assign sweep_done    = sweep_done_q;

endmodule

// File: tb/tb_ro_sensor_scheduler.sv
// Scoreboard bench for ro_sensor_scheduler: expected results are queued when
// a sweep is started and popped as the DUT hands them off.
module tb_ro_sensor_scheduler;

    localparam int N       = 4;
    localparam int W       = 64;
    localparam int EN_HOLD = 2;
    localparam int SETTLE  = 4;

    typedef struct packed {
        logic [1:0]   chan;
        logic [W-1:0] count;
        logic         alarm;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [N-1:0]      chan_mask = '0;
    logic [W-1:0]      meas_time = '0;
    logic [W-1:0]      alarm_threshold = '0;
    logic [N-1:0]      ro_counter_en;
    logic [W-1:0]      ro_meas_time;
    logic [N-1:0][W-1:0] cnts;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [1:0]        res_chan;
    logic [W-1:0]      res_count;
    logic              res_alarm;
    logic              busy;
    logic              sweep_done;

    res_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           t0 = 0;
    int           sd_cnt = 0;
    int           en_cyc = 0;
    int           lat;
    logic [N-1:0] en_seen = '0;
    logic [W:0]   pre;

    ro_sensor_scheduler #(
        .NUM_SENSORS (N),
        .WIDTH       (W),
        .EN_HOLD     (EN_HOLD),
        .SETTLE      (SETTLE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .continuous      (continuous),
        .chan_mask       (chan_mask),
        .meas_time       (meas_time),
        .alarm_threshold (alarm_threshold),
        .ro_counter_en   (ro_counter_en),
        .ro_meas_time    (ro_meas_time),
        .ro_meas_count   (cnts),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_chan        (res_chan),
        .res_count       (res_count),
        .res_alarm       (res_alarm),
        .busy            (busy),
        .sweep_done      (sweep_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: enable sanity, sweep_done count, scoreboard compare on handshake.
    always @(negedge clk) begin : mon
        res_t e;
        if (!rst) begin
            if (sweep_done) sd_cnt++;
            en_seen |= ro_counter_en;
            en_cyc  += $countones(ro_counter_en);
            if (ro_counter_en != '0) chk("en_onehot", W'($countones(ro_counter_en)), 64'd1);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_result", W'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("res_chan", W'(res_chan), W'(e.chan));
                    chk("res_count", res_count, e.count);
                    chk("res_alarm", W'(res_alarm), W'(e.alarm));
                end
            end
        end
    end

    task automatic push(input logic [1:0] c, input logic [W-1:0] v, input logic a);
        res_t e;
        e.chan = c; e.count = v; e.alarm = a;
        sb.push_back(e);
    endtask

    task automatic kick(input logic [N-1:0] m, input logic [W-1:0] mt,
                        input logic [W-1:0] th, input logic c);
        @(negedge clk);
        chan_mask = m; meas_time = mt; alarm_threshold = th; continuous = c; start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int l);
        for (int i = 0; i < maxc && !res_valid; i++) @(negedge clk);
        if (!res_valid) chk("tmo_valid", W'(res_valid), 64'd1);
        l = cyc - t0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        for (int i = 0; i < maxc && busy; i++) @(negedge clk);
        chk(tag, W'(busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        cnts = '0;
        // Reset state
        #12;
        chk("rst_busy", W'(busy), 64'd0);
        chk("rst_valid", W'(res_valid), 64'd0);
        chk("rst_en", W'(ro_counter_en), 64'd0);
        chk("rst_mtime", ro_meas_time, 64'd0);
        chk("rst_done", W'(sweep_done), 64'd0);
        chk("rst_count", res_count, 64'd0);
        @(negedge clk) rst = 1'b0;

        // Single sweep over mask 1011
        cnts[0] = 64'd100; cnts[1] = 64'd50; cnts[2] = 64'd999; cnts[3] = 64'd7;
        push(2'd0, 64'd100, 1'b0); push(2'd1, 64'd50, 1'b1); push(2'd3, 64'd7, 1'b1);
        sd_cnt = 0; en_seen = '0; en_cyc = 0;
        kick(4'b1011, 64'd10, 64'd60, 1'b0);
        wait_valid(100, lat);
        chk("lat_mt10", W'(lat), W'(EN_HOLD + 10 + SETTLE + 2));
        wait_idle(300, "tmo_sweep1");
        chk("sweep1_done", W'(sd_cnt), 64'd1);
        chk("sweep1_en_seen", W'(en_seen), 64'b1011);
        chk("sweep1_en_cycles", W'(en_cyc), W'(3 * EN_HOLD));
        chk("sweep1_sb_empty", W'(sb.size()), 64'd0);

        // Backpressure on the first result
        push(2'd0, 64'd100, 1'b0); push(2'd1, 64'd50, 1'b1); push(2'd3, 64'd7, 1'b1);
        sd_cnt = 0;
        res_ready = 1'b0;
        kick(4'b1011, 64'd10, 64'd60, 1'b0);
        wait_valid(100, lat);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", W'(res_valid), 64'd1);
            chk("bp_count", res_count, 64'd100);
            chk("bp_en", W'(ro_counter_en), 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_idle(300, "tmo_bp");
        chk("bp_done", W'(sd_cnt), 64'd1);
        chk("bp_sb_empty", W'(sb.size()), 64'd0);

        // Continuous with stop during the third sweep's WAIT
        for (int i = 0; i < 3; i++) push(2'd0, 64'd100, 1'b0);
        sd_cnt = 0;
        kick(4'b0001, 64'd5, 64'd60, 1'b1);
        for (int i = 0; i < 200 && sd_cnt < 2; i++) @(negedge clk);
        chk("cont_two_sweeps", W'(sd_cnt), 64'd2);
        for (int i = 0; i < 20 && ro_counter_en != '0; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        continuous = 1'b0;
        wait_idle(200, "tmo_stop");
        chk("stop_done", W'(sd_cnt), 64'd3);
        chk("stop_sb_empty", W'(sb.size()), 64'd0);

        // Empty mask: nothing happens
        sd_cnt = 0;
        kick(4'b0000, 64'd5, 64'd60, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("mask0_busy", W'(busy), 64'd0);
            chk("mask0_en", W'(ro_counter_en), 64'd0);
            @(negedge clk);
        end
        chk("mask0_done", W'(sd_cnt), 64'd0);

        // meas_time = 0 and threshold = 0 with a zero count
        cnts[0] = 64'd0;
        push(2'd0, 64'd0, 1'b0);
        kick(4'b0001, 64'd0, 64'd0, 1'b0);
        wait_valid(50, lat);
        chk("lat_mt0", W'(lat), W'(EN_HOLD + SETTLE + 2));
        wait_idle(50, "tmo_mt0");

        // meas_time all-ones: preload the wait counter near the top
        push(2'd1, 64'd50, 1'b1);
        kick(4'b0010, {W{1'b1}}, {W{1'b1}}, 1'b0);
        chk("max_mtime", ro_meas_time, {W{1'b1}});
        for (int i = 0; i < 20 && ro_counter_en == '0; i++) @(negedge clk);
        for (int i = 0; i < 20 && ro_counter_en != '0; i++) @(negedge clk);
        pre = {1'b0, {W{1'b1}}} - 65'd1;
        force dut.cnt_q = pre;
        @(negedge clk);
        release dut.cnt_q;
        wait_valid(30, lat);
        wait_idle(30, "tmo_max");

        // Asynchronous reset mid-WAIT
        cnts[0] = 64'd100;
        kick(4'b0001, 64'd20, 64'd60, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", W'(ro_counter_en), 64'd0);
        chk("arst_valid", W'(res_valid), 64'd0);
        chk("arst_busy", W'(busy), 64'd0);
        @(negedge clk) rst = 1'b0;
        en_seen = '0;
        push(2'd2, 64'd999, 1'b0);
        kick(4'b0100, 64'd3, 64'd60, 1'b0);
        wait_idle(100, "tmo_arst");
        chk("arst_en_seen", W'(en_seen), 64'b0100);

        // Config changes and a second start during a sweep are ignored
        push(2'd0, 64'd100, 1'b0); push(2'd1, 64'd50, 1'b1); push(2'd3, 64'd7, 1'b1);
        sd_cnt = 0; en_seen = '0;
        kick(4'b1011, 64'd10, 64'd60, 1'b0);
        repeat (4) @(negedge clk);
        chan_mask = 4'b0100; meas_time = 64'd0; alarm_threshold = 64'd0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("cfg_mtime", ro_meas_time, 64'd10);
        wait_idle(300, "tmo_cfg");
        chk("cfg_done", W'(sd_cnt), 64'd1);
        chk("cfg_en_seen", W'(en_seen), 64'b1011);
        chk("final_sb_empty", W'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
